// File: rtl/rangefinder_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rangefinder_mem_pkg
// Description : Shared definitions for the rangefinder dual-port RAM slice:
//               sweep/run state encoding, read-latency ceiling, byte width
//               and the per-byte even-parity helper.
// Revision    : 1.0  initial release
// ============================================================================
package rangefinder_mem_pkg;

    // Deepest read pipeline the top supports (core register + output register)
    localparam int c_MAX_READ_LATENCY = 2;
    localparam int c_BYTE_W           = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } dpram_state_e;

    // Even parity: the stored bit makes the 9-bit lane have an even number of ones
    function automatic logic even_parity(input logic [c_BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rangefinder_dpram_core.sv
`default_nettype none
// ============================================================================
// Module      : rangefinder_dpram_core
// Description : Inferred true dual-port RAM, LANES lanes of LANE_W bits per
//               word, per-lane write enables, registered read on both ports.
//               A read returns the word as it was before any write in the
//               same cycle (old-data semantics on both ports).
// Ports       : clk                     clock
//               i_a_we / i_b_we         per-lane write enables
//               i_a_addr / i_b_addr     word addresses
//               i_a_wdata / i_b_wdata   write words
//               o_a_rdata / o_b_rdata   registered read words
// Revision    : 1.0  initial release
// ============================================================================
module rangefinder_dpram_core #(
    parameter int ADDR_W = 13,
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic [LANES-1:0]          i_a_we,
    input  logic [ADDR_W-1:0]         i_a_addr,
    input  logic [LANES*LANE_W-1:0]   i_a_wdata,
    output logic [LANES*LANE_W-1:0]   o_a_rdata,
    input  logic [LANES-1:0]          i_b_we,
    input  logic [ADDR_W-1:0]         i_b_addr,
    input  logic [LANES*LANE_W-1:0]   i_b_wdata,
    output logic [LANES*LANE_W-1:0]   o_b_rdata
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [LANES*LANE_W-1:0] r_mem [c_DEPTH];
    logic [LANES*LANE_W-1:0] r_a_rdata;
    logic [LANES*LANE_W-1:0] r_b_rdata;

    // Port A is applied after port B so that A owns any lane both enable;
    // the top already masks such lanes off port B, so this is only a backstop.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_b_we[i]) r_mem[i_b_addr][i*LANE_W +: LANE_W] <= i_b_wdata[i*LANE_W +: LANE_W];
            if (i_a_we[i]) r_mem[i_a_addr][i*LANE_W +: LANE_W] <= i_a_wdata[i*LANE_W +: LANE_W];
        end
        r_a_rdata <= r_mem[i_a_addr];
        r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/rangefinder_dpram_avmm.sv
`default_nettype none
// ============================================================================
// Module      : rangefinder_dpram_avmm
// Description : Parametrised true dual-port RAM behind two Avalon-MM slaves
//               (s1 = CPU, s2 = DMA). Optional zero-fill sweep after reset,
//               READ_LATENCY of 1 or 2 with readdatavalid, byte enables, and
//               same-address write collision detection with a saturating count.
// Options     : RFD_DPRAM_PARITY_EN - store one even-parity bit per byte,
//               check it on every read, add s1_parity_err / s2_parity_err.
// Ports       : clk, reset_n (synchronous, active low)
//               s1_* / s2_*   address, byteenable, read, write, writedata,
//                             readdata, readdatavalid, waitrequest
//               wr_collision  one-cycle pulse after a same-address double write
//               collision_cnt saturating collision count
//               busy          clear sweep in progress
// Revision    : 1.0  initial release
// ============================================================================
module rangefinder_dpram_avmm
    import rangefinder_mem_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest,
    output logic                  wr_collision,
    output logic [CNT_W-1:0]      collision_cnt,
    output logic                  busy
`ifdef RFD_DPRAM_PARITY_EN
    ,
    output logic                  s1_parity_err,
    output logic                  s2_parity_err
`endif
);

    localparam int c_NB = DATA_W / c_BYTE_W;
`ifdef RFD_DPRAM_PARITY_EN
    localparam int c_LANE_W = c_BYTE_W + 1;
`else
    localparam int c_LANE_W = c_BYTE_W;
`endif
    localparam int c_MEM_W = c_NB * c_LANE_W;

    // Lane i of a stored word is {parity, byte} when parity is enabled
    function automatic logic [c_MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
        logic [c_MEM_W-1:0] w;
        w = '0;
        for (int i = 0; i < c_NB; i++) begin
`ifdef RFD_DPRAM_PARITY_EN
            w[i*c_LANE_W +: c_LANE_W] = {even_parity(d[i*c_BYTE_W +: c_BYTE_W]), d[i*c_BYTE_W +: c_BYTE_W]};
`else
            w[i*c_LANE_W +: c_LANE_W] = d[i*c_BYTE_W +: c_BYTE_W];
`endif
        end
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] unpack_data(input logic [c_MEM_W-1:0] w);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < c_NB; i++) d[i*c_BYTE_W +: c_BYTE_W] = w[i*c_LANE_W +: c_BYTE_W];
        return d;
    endfunction

`ifdef RFD_DPRAM_PARITY_EN
    function automatic logic word_parity_err(input logic [c_MEM_W-1:0] w);
        logic e;
        e = 1'b0;
        for (int i = 0; i < c_NB; i++)
            e = e | (w[i*c_LANE_W + c_BYTE_W] != even_parity(w[i*c_LANE_W +: c_BYTE_W]));
        return e;
    endfunction
`endif

    dpram_state_e        r_state;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_wr_collision;
    logic [CNT_W-1:0]    r_collision_cnt;
    logic                r_s1_v1;
    logic                r_s2_v1;

    logic                w_run;
    logic                w_s1_wr, w_s1_rd, w_s2_wr, w_s2_rd, w_coll;
    logic [c_NB-1:0]     w_a_we, w_b_we;
    logic [ADDR_W-1:0]   w_a_addr;
    logic [c_MEM_W-1:0]  w_a_wdata, w_b_wdata, w_a_rdata, w_b_rdata;
    logic [DATA_W-1:0]   w_s1_d1, w_s2_d1;

    assign w_run   = (r_state == ST_RUN);
    // A port asserting read and write together performs only the write
    assign w_s1_wr = w_run & s1_write;
    assign w_s2_wr = w_run & s2_write;
    assign w_s1_rd = w_run & s1_read & ~s1_write;
    assign w_s2_rd = w_run & s2_read & ~s2_write;
    assign w_coll  = w_s1_wr & w_s2_wr & (s1_address == s2_address);

    // Port A carries s1 traffic in RUN and the zero-fill sweep in CLEAR;
    // pack_word keeps the sweep's parity bits consistent.
    always_comb begin
        w_a_we    = '0;
        w_a_addr  = s1_address;
        w_a_wdata = pack_word(s1_writedata);
        if (!w_run) begin
            w_a_we    = '1;
            w_a_addr  = r_clr_addr;
            w_a_wdata = pack_word('0);
        end else if (w_s1_wr) begin
            w_a_we    = s1_byteenable;
        end
    end

    // On a collision s1 owns its enabled lanes; s2 still fills the others
    assign w_b_we    = w_s2_wr ? (s2_byteenable & ~(w_coll ? s1_byteenable : '0)) : '0;
    assign w_b_wdata = pack_word(s2_writedata);

    rangefinder_dpram_core #(
        .ADDR_W (ADDR_W),
        .LANES  (c_NB),
        .LANE_W (c_LANE_W)
    ) u_core (
        .clk       (clk),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .o_a_rdata (w_a_rdata),
        .i_b_we    (w_b_we),
        .i_b_addr  (s2_address),
        .i_b_wdata (w_b_wdata),
        .o_b_rdata (w_b_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_addr      <= '0;
            r_wr_collision  <= 1'b0;
            r_collision_cnt <= '0;
            r_s1_v1         <= 1'b0;
            r_s2_v1         <= 1'b0;
        end else begin
            r_wr_collision <= w_coll;
            if (w_coll && (r_collision_cnt != '1))
                r_collision_cnt <= r_collision_cnt + CNT_W'(1);
            r_s1_v1 <= w_s1_rd;
            r_s2_v1 <= w_s2_rd;
            if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
                if (r_clr_addr == '1) r_state <= ST_RUN;
            end
        end
    end

    // Read data is forced to zero outside its valid cycle
    assign w_s1_d1 = r_s1_v1 ? unpack_data(w_a_rdata) : '0;
    assign w_s2_d1 = r_s2_v1 ? unpack_data(w_b_rdata) : '0;
`ifdef RFD_DPRAM_PARITY_EN
    logic w_s1_pe1, w_s2_pe1;
    assign w_s1_pe1 = r_s1_v1 & word_parity_err(w_a_rdata);
    assign w_s2_pe1 = r_s2_v1 & word_parity_err(w_b_rdata);
`endif

    generate
        if (READ_LATENCY >= c_MAX_READ_LATENCY) begin : g_lat2
            logic              r_s1_v2, r_s2_v2;
            logic [DATA_W-1:0] r_s1_d2, r_s2_d2;
`ifdef RFD_DPRAM_PARITY_EN
            logic              r_s1_pe2, r_s2_pe2;
`endif
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_s1_v2 <= 1'b0;
                    r_s2_v2 <= 1'b0;
                    r_s1_d2 <= '0;
                    r_s2_d2 <= '0;
`ifdef RFD_DPRAM_PARITY_EN
                    r_s1_pe2 <= 1'b0;
                    r_s2_pe2 <= 1'b0;
`endif
                end else begin
                    r_s1_v2 <= r_s1_v1;
                    r_s2_v2 <= r_s2_v1;
                    r_s1_d2 <= w_s1_d1;
                    r_s2_d2 <= w_s2_d1;
`ifdef RFD_DPRAM_PARITY_EN
                    r_s1_pe2 <= w_s1_pe1;
                    r_s2_pe2 <= w_s2_pe1;
`endif
                end
            end
            assign s1_readdatavalid = r_s1_v2;
            assign s2_readdatavalid = r_s2_v2;
            assign s1_readdata      = r_s1_d2;
            assign s2_readdata      = r_s2_d2;
`ifdef RFD_DPRAM_PARITY_EN
            assign s1_parity_err    = r_s1_pe2;
            assign s2_parity_err    = r_s2_pe2;
`endif
        end else begin : g_lat1
            assign s1_readdatavalid = r_s1_v1;
            assign s2_readdatavalid = r_s2_v1;
            assign s1_readdata      = w_s1_d1;
            assign s2_readdata      = w_s2_d1;
`ifdef RFD_DPRAM_PARITY_EN
            assign s1_parity_err    = w_s1_pe1;
            assign s2_parity_err    = w_s2_pe1;
`endif
        end
    endgenerate

    assign busy           = ~w_run;
    assign s1_waitrequest = ~w_run;
    assign s2_waitrequest = ~w_run;
    assign wr_collision   = r_wr_collision;
    assign collision_cnt  = r_collision_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rangefinder_dpram_avmm.sv
`default_nettype none
// ============================================================================
// Module      : tb_rangefinder_dpram_avmm
// Description : Self-checking bench for rangefinder_dpram_avmm (16 words,
//               32-bit data, 2-bit collision counter). A word-array reference
//               model predicts every read, collision pulse and count.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rangefinder_dpram_avmm;

    localparam int c_DW    = 32;
    localparam int c_AW    = 4;
    localparam int c_LAT   = 1;
    localparam int c_CW    = 2;
    localparam int c_DEPTH = 16;
    localparam int c_CMAX  = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [c_AW-1:0]   s1_address, s2_address;
    logic [3:0]        s1_byteenable, s2_byteenable;
    logic              s1_read, s1_write, s2_read, s2_write;
    logic [c_DW-1:0]   s1_writedata, s2_writedata;
    logic [c_DW-1:0]   s1_readdata, s2_readdata;
    logic              s1_readdatavalid, s2_readdatavalid;
    logic              s1_waitrequest, s2_waitrequest;
    logic              wr_collision;
    logic [c_CW-1:0]   collision_cnt;
    logic              busy;
`ifdef RFD_DPRAM_PARITY_EN
    logic              s1_parity_err, s2_parity_err;
`endif

    always #5 clk = ~clk;

    rangefinder_dpram_avmm #(
        .DATA_W(c_DW), .ADDR_W(c_AW), .READ_LATENCY(c_LAT), .CLEAR_ON_RESET(1), .CNT_W(c_CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
        .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
        .wr_collision(wr_collision), .collision_cnt(collision_cnt), .busy(busy)
`ifdef RFD_DPRAM_PARITY_EN
        , .s1_parity_err(s1_parity_err), .s2_parity_err(s2_parity_err)
`endif
    );

    typedef struct packed {
        logic            r;
        logic            w;
        logic [c_AW-1:0] a;
        logic [3:0]      be;
        logic [c_DW-1:0] d;
    } cmd_t;

    typedef struct {
        int              due;
        logic [c_DW-1:0] data;
        logic            pe;
    } rd_t;

    localparam cmd_t c_IDLE = '0;

    logic [c_DW-1:0]    mem [c_DEPTH];
    logic [c_DEPTH-1:0] pe_bad;
    rd_t                q1[$];
    rd_t                q2[$];
    int                 cyc      = 0;
    int                 exp_cnt  = 0;
    int                 n_total  = 0;
    int                 n_bad    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic r, input logic w, input logic [c_AW-1:0] a,
                                input logic [3:0] be, input logic [c_DW-1:0] d);
        cmd_t c;
        c.r = r; c.w = w; c.a = a; c.be = be; c.d = d;
        return c;
    endfunction

    function automatic void model_write(input cmd_t c);
        for (int i = 0; i < 4; i++)
            if (c.be[i]) mem[c.a][8*i +: 8] = c.d[8*i +: 8];
        if (c.be[0]) pe_bad[c.a] = 1'b0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < c_DEPTH; i++) mem[i] = '0;
        pe_bad  = '0;
        exp_cnt = 0;
        q1.delete();
        q2.delete();
    endfunction

    // Called at a negedge: drives one command per port, advances the model,
    // crosses one rising edge and checks everything visible at the next negedge.
    task automatic step(input cmd_t c1, input cmd_t c2);
        rd_t  e;
        logic coll;
        logic ev1, ev2;
        logic [c_DW-1:0] ed1, ed2;
        logic ep1, ep2;
        s1_read = c1.r; s1_write = c1.w; s1_address = c1.a; s1_byteenable = c1.be; s1_writedata = c1.d;
        s2_read = c2.r; s2_write = c2.w; s2_address = c2.a; s2_byteenable = c2.be; s2_writedata = c2.d;
        if (c1.r && !c1.w) begin e.due = cyc + c_LAT; e.data = mem[c1.a]; e.pe = pe_bad[c1.a]; q1.push_back(e); end
        if (c2.r && !c2.w) begin e.due = cyc + c_LAT; e.data = mem[c2.a]; e.pe = pe_bad[c2.a]; q2.push_back(e); end
        coll = c1.w && c2.w && (c1.a == c2.a);
        if (c2.w) model_write(c2);
        if (c1.w) model_write(c1);   // s1 wins every lane it enables
        if (coll && exp_cnt < c_CMAX) exp_cnt++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        ev2 = (q2.size() > 0) && (q2[0].due == cyc);
        ed1 = ev1 ? q1[0].data : '0;
        ed2 = ev2 ? q2[0].data : '0;
        ep1 = ev1 ? q1[0].pe : 1'b0;
        ep2 = ev2 ? q2[0].pe : 1'b0;
        if (ev1) void'(q1.pop_front());
        if (ev2) void'(q2.pop_front());
        chk("s1_rdvalid", s1_readdatavalid, ev1);
        chk("s1_rdata", s1_readdata, ed1);
        chk("s2_rdvalid", s2_readdatavalid, ev2);
        chk("s2_rdata", s2_readdata, ed2);
        chk("wr_collision", wr_collision, coll);
        chk("collision_cnt", collision_cnt, exp_cnt);
`ifdef RFD_DPRAM_PARITY_EN
        chk("s1_parity_err", s1_parity_err, ep1);
        chk("s2_parity_err", s2_parity_err, ep2);
`else
        if (ep1 || ep2) chk("parity_model", 1'b1, 1'b0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(c_IDLE, c_IDLE);
    endtask

    // Entered at a negedge with reset_n just released
    task automatic wait_sweep();
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) done = 1'b1;
        end
        chk("sweep_len", n, c_DEPTH);
        @(negedge clk);
        chk("s1_wait_run", s1_waitrequest, 1'b0);
        chk("s2_wait_run", s2_waitrequest, 1'b0);
        model_clear();
    endtask

    task automatic read_all();
        for (int i = 0; i < c_DEPTH; i++)
            step(mk(1'b1, 1'b0, c_AW'(i), 4'h0, '0), mk(1'b1, 1'b0, c_AW'(c_DEPTH-1-i), 4'h0, '0));
        idle(3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    initial begin
        cmd_t c1, c2;
        reset_n = 1'b0;
        s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
        s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
        pe_bad = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b1);
        chk("rst_s1_wait", s1_waitrequest, 1'b1);
        chk("rst_s2_wait", s2_waitrequest, 1'b1);
        chk("rst_s1_rdv", s1_readdatavalid, 1'b0);
        chk("rst_s2_rdv", s2_readdatavalid, 1'b0);
        chk("rst_s1_rdata", s1_readdata, '0);
        chk("rst_s2_rdata", s2_readdata, '0);
        chk("rst_coll", wr_collision, 1'b0);
        chk("rst_cnt", collision_cnt, '0);
        reset_n = 1'b1;
        wait_sweep();
        read_all();

        // Partial byte write from s1, read back through s2
        step(mk(1'b0, 1'b1, 4'd5, 4'b0101, 32'hDEADBEEF), c_IDLE);
        step(c_IDLE, mk(1'b1, 1'b0, 4'd5, 4'h0, '0));
        idle(2);

        // Fill 0..7 from s2, then eight back-to-back s1 reads
        for (int i = 0; i < 8; i++) step(c_IDLE, mk(1'b0, 1'b1, c_AW'(i), 4'hF, $urandom));
        for (int i = 0; i < 8; i++) step(mk(1'b1, 1'b0, c_AW'(i), 4'h0, '0), c_IDLE);
        idle(2);

        // Full-lane collision, then reads of the winner from both ports
        step(mk(1'b0, 1'b1, 4'd3, 4'hF, 32'h11111111), mk(1'b0, 1'b1, 4'd3, 4'hF, 32'h22222222));
        step(c_IDLE, c_IDLE);
        step(mk(1'b1, 1'b0, 4'd3, 4'h0, '0), mk(1'b1, 1'b0, 4'd3, 4'h0, '0));
        idle(2);
        // Further partial-lane collisions drive the 2-bit counter into saturation
        for (int k = 0; k < 4; k++) begin
            step(mk(1'b0, 1'b1, 4'd3, 4'b0011, $urandom), mk(1'b0, 1'b1, 4'd3, 4'b1110, $urandom));
            step(mk(1'b1, 1'b0, 4'd3, 4'h0, '0), c_IDLE);
        end
        idle(2);

        // Cross-port read during write sees old data; same-port read next cycle sees new
        step(mk(1'b0, 1'b1, 4'd9, 4'hF, 32'hA5A5C3C3), mk(1'b1, 1'b0, 4'd9, 4'h0, '0));
        step(mk(1'b1, 1'b0, 4'd9, 4'h0, '0), mk(1'b0, 1'b1, 4'd10, 4'hF, 32'h0BADF00D));
        step(c_IDLE, mk(1'b1, 1'b0, 4'd10, 4'h0, '0));
        // Read+write together acts as a write only; be=0 write changes nothing
        step(mk(1'b1, 1'b1, 4'd11, 4'hF, 32'h13579BDF), c_IDLE);
        step(mk(1'b0, 1'b1, 4'd11, 4'h0, 32'hFFFFFFFF), mk(1'b1, 1'b0, 4'd11, 4'h0, '0));
        step(mk(1'b1, 1'b0, 4'd11, 4'h0, '0), c_IDLE);
        idle(2);

        // Random traffic concentrated on a few addresses to provoke collisions
        for (int i = 0; i < 400; i++) begin
            c1 = mk(1'($urandom), 1'($urandom), c_AW'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3)),
                    4'($urandom), $urandom);
            c2 = mk(1'($urandom), 1'($urandom), c_AW'(($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3)),
                    4'($urandom), $urandom);
            step(c1, c2);
        end
        idle(3);

`ifdef RFD_DPRAM_PARITY_EN
        // Corrupt one stored data bit behind the RAM's back and read it
        step(mk(1'b0, 1'b1, 4'd2, 4'hF, 32'h0000005A), c_IDLE);
        dut.u_core.r_mem[2][0] = ~dut.u_core.r_mem[2][0];
        mem[2][0] = ~mem[2][0];
        pe_bad[2] = 1'b1;
        step(mk(1'b1, 1'b0, 4'd2, 4'h0, '0), mk(1'b1, 1'b0, 4'd2, 4'h0, '0));
        idle(2);
`endif

        // Reset in the middle of the sweep restarts it from word 0
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("midsweep_busy", busy, 1'b1);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 1'b1);
        chk("midrst_cnt", collision_cnt, '0);
        chk("midrst_coll", wr_collision, 1'b0);
        reset_n = 1'b1;
        wait_sweep();
        read_all();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
